sd_frame_sequencer: RTL



---
 rtl/sd_frame_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sd_frame_sequencer.sv
// Frame readout sequencer for a bank of synchronised sigma-delta decimators.
// A result strobe snapshots all channel words into a shadow register. The words
// are then streamed one per valid/ready handshake, in channel order. A strobe
// that arrives while a frame is still streaming is dropped and flagged as an
// overrun. All outputs come straight from registers.
module sd_frame_sequencer #(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned CH_WIDTH  = $clog2(CHANNELS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic                           new_value_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic [CH_WIDTH-1:0]            m_channel_o,
  output logic                           m_last_o,
  output logic                           busy_o,
  output logic                           overrun_o,
  input  logic                           overrun_clr_i,
  output logic [15:0]                    frame_count_o
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shadow_q [CHANNELS];
  logic [DATA_WIDTH-1:0] shadow_d [CHANNELS];
  logic [CH_WIDTH-1:0]   idx_q, idx_d, idx_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic in_send, handshake, final_hs, capture, drop;

  assign in_send   = (state_q == StSend);
  assign handshake = in_send && m_ready_i;
  assign final_hs  = handshake && last_q;
  // A strobe landing on the final handshake starts the next frame back-to-back.
  assign capture   = new_value_i && enable_i && (!in_send || final_hs);
  // Overrun detection ignores enable_i: any strobe mid-frame loses a period.
  assign drop      = new_value_i && in_send && !final_hs;
  assign idx_nxt   = idx_q + CH_WIDTH'(1);

  // Next-state: capture, channel advance, frame counting and overrun flag.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    data_d        = data_q;
    last_d        = last_q;
    shadow_d      = shadow_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    if (final_hs) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    // Set has priority over clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end

    if (capture) begin
      state_d = StSend;
      idx_d   = '0;
      data_d  = data_i[DATA_WIDTH-1:0];
      last_d  = 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        shadow_d[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (final_hs) begin
      state_d = StIdle;
      idx_d   = '0;
      data_d  = '0;
      last_d  = 1'b0;
    end else if (handshake) begin
      idx_d  = idx_nxt;
      data_d = shadow_q[idx_nxt];
      last_d = (idx_nxt == CH_WIDTH'(CHANNELS - 1));
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      last_q        <= last_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      shadow_q      <= shadow_d;
    end
  end

  assign m_valid_o     = in_send;
  assign busy_o        = in_send;
  assign m_data_o      = data_q;
  assign m_channel_o   = idx_q;
  assign m_last_o      = last_q;
  assign overrun_o     = overrun_q;
  assign frame_count_o = frame_count_q;

endmodule
